fifo_pop_arbiter_rr: RTL and testbench

//   Reader end of the four fifo_c queues. Round-robin arbiter that issues pops to up to 4 source FIFOs.

---
 rtl/fifo_pop_arbiter_rr.sv | 100 ++++++++++
 tb/tb_fifo_pop_arbiter_rr.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_arbiter_rr.sv
// fifo_pop_arbiter_rr: round-robin pop arbiter over four source FIFOs feeding one downstream FIFO.
// Define FIFO_POP_ARB_CNT_EN to add per-queue pushed-word counters on cnt_word.
module fifo_pop_arbiter_rr #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    fifo_empty,
    input  logic [3:0]    valid_in,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    input  logic [DW-1:0] data_in2,
    input  logic [DW-1:0] data_in3,
    input  logic          pause,
    output logic [3:0]    pop,
    output logic          push_out,
    output logic [DW-1:0] data_out,
    output logic [1:0]    src_id,
    output logic          arb_error
`ifdef FIFO_POP_ARB_CNT_EN
    ,
    output logic [4*8-1:0] cnt_word
`endif
);
    typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE, ERROR} state_t;
    state_t state, state_nx;
    logic [1:0] rr_ptr, pend_id, grant_id, idx;
    logic [3:0] elig, pop_nx;
    logic pend, grant_vld, err_det, do_push;
    logic [DW-1:0] din [4];
    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;
    // a queue popped last cycle may still show non-empty, so it sits out one decision
    assign elig = ~fifo_empty & ~pop;
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_ptr;
        idx       = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end
    assign err_det = pend ? (valid_in != (4'b0001 << pend_id)) : |valid_in;
    assign do_push = (state != ERROR) && pend && !err_det;
    always_comb begin
        state_nx = state;
        pop_nx   = 4'b0000;
        if (state == ERROR || err_det)
            state_nx = ERROR;
        else if (pause)
            state_nx = PAUSE;
        else if (grant_vld) begin
            state_nx = ACTIVE;
            pop_nx   = 4'b0001 << grant_id;
        end else
            state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 2'd3;
            pop       <= 4'b0000;
            pend      <= 1'b0;
            pend_id   <= 2'd0;
            push_out  <= 1'b0;
            data_out  <= '0;
            src_id    <= 2'd0;
            arb_error <= 1'b0;
        end else begin
            state     <= state_nx;
            pop       <= pop_nx;
            if (|pop_nx)
                rr_ptr <= grant_id;
            pend      <= |pop;
            pend_id   <= {pop[3] | pop[2], pop[3] | pop[1]};
            push_out  <= do_push;
            if (do_push) begin
                data_out <= din[pend_id];
                src_id   <= pend_id;
            end
            arb_error <= (state_nx == ERROR);
        end
    end
`ifdef FIFO_POP_ARB_CNT_EN
    logic [7:0] cnt [4];
    always_ff @(posedge clk) begin
        if (reset)
            for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
        else if (push_out)
            cnt[src_id] <= cnt[src_id] + 8'd1;
    end
    assign cnt_word = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif
endmodule

// File: tb/tb_fifo_pop_arbiter_rr.sv
// tb_fifo_pop_arbiter_rr: scoreboard bench with a behavioural model of the four source FIFOs.
module tb_fifo_pop_arbiter_rr;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] fifo_empty, valid_in, pop;
    logic [3:0] vq = 4'b0;
    logic [3:0] inj = 4'b0;
    logic pause = 1'b0;
    logic drop = 1'b0;
    logic push_out, arb_error;
    logic [7:0] dq [4] = '{default: 8'h00};
    logic [7:0] data_out;
    logic [1:0] src_id;
`ifdef FIFO_POP_ARB_CNT_EN
    logic [31:0] cnt_word;
`endif
    logic [7:0] mem [4][16];
    int wr [4] = '{default: 0};
    int rd [4] = '{default: 0};
    logic [9:0] exp_q [$];
    logic [9:0] mon_e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_pop_arbiter_rr #(.DW(8)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .valid_in(valid_in),
        .data_in0(dq[0]), .data_in1(dq[1]), .data_in2(dq[2]), .data_in3(dq[3]),
        .pause(pause), .pop(pop), .push_out(push_out), .data_out(data_out),
        .src_id(src_id), .arb_error(arb_error)
`ifdef FIFO_POP_ARB_CNT_EN
        , .cnt_word(cnt_word)
`endif
    );

    // source FIFO model: data and valid return one cycle after a pop
    always_comb for (int i = 0; i < 4; i++) fifo_empty[i] = (rd[i] == wr[i]);
    assign valid_in = vq | inj;
    always @(posedge clk) begin
        vq <= (reset || drop) ? 4'b0 : pop;
        for (int i = 0; i < 4; i++)
            if (pop[i] && rd[i] != wr[i]) begin
                dq[i] <= mem[i][rd[i] % 16];
                rd[i] <= rd[i] + 1;
            end
    end

    always @(negedge clk) begin
        if (push_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push: got src_id=%0d data_out=%h, expected no push", src_id, data_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({src_id, data_out} !== mon_e) begin
                    errors++;
                    $display("FAIL push_data: got src_id=%0d data_out=%h, expected src_id=%0d data_out=%h",
                             src_id, data_out, mon_e[9:8], mon_e[7:0]);
                end
            end
        end
    end

    function automatic logic [7:0] word(input int q, input int k);
        return 8'((10 + q) * 16 + k);
    endfunction

    task automatic load_word(input int q, input logic [7:0] v);
        mem[q][wr[q] % 16] = v;
        wr[q] = wr[q] + 1;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words still expected after timeout, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int q = 0; q < 4; q++) begin
                load_word(q, word(q, k));
                exp_q.push_back({2'(q), word(q, k)});
            end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({pop, push_out, arb_error, data_out, src_id} !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs: got pop=%b push=%b err=%b data=%h src=%0d, expected all 0",
                         pop, push_out, arb_error, data_out, src_id);
            end
        end
    endtask

    task automatic test_rotation();
        int t = 0;
        int run = 0;
        reset = 1'b0;
        while (!push_out && t < 20) begin
            @(negedge clk);
            t++;
        end
        while (push_out && run < 20) begin
            run++;
            @(negedge clk);
        end
        checks++;
        if (run !== 12) begin
            errors++;
            $display("FAIL rotation_back_to_back: got %0d consecutive pushes, expected 12", run);
        end
`ifdef FIFO_POP_ARB_CNT_EN
        checks++;
        if (cnt_word !== {8'd3, 8'd3, 8'd3, 8'd3}) begin
            errors++;
            $display("FAIL cnt_word_rotation: got %h, expected 03030303", cnt_word);
        end
`endif
        wait_drain("rotation");
        checks++;
        if (pop !== 4'b0 || arb_error !== 1'b0) begin
            errors++;
            $display("FAIL rotation_idle: got pop=%b err=%b, expected 0000 and 0", pop, arb_error);
        end
    endtask

    task automatic test_single_queue();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            load_word(2, word(2, k));
            exp_q.push_back({2'd2, word(2, k)});
        end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (pop !== ((k % 2 == 0 && k < 6) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL single_pop_cycle%0d: got pop=%b, expected %b", k, pop,
                         (k % 2 == 0 && k < 6) ? 4'b0100 : 4'b0000);
            end
        end
        wait_drain("single");
        checks++;
        if (arb_error !== 1'b0) begin
            errors++;
            $display("FAIL single_error: got arb_error=%b, expected 0", arb_error);
        end
    endtask

    task automatic test_pause();
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 4; j++) begin
                load_word((3 + j) % 4, word((3 + j) % 4, k));
                exp_q.push_back({2'((3 + j) % 4), word((3 + j) % 4, k)});
            end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pop !== 4'(1 << ((3 + i) % 4))) begin
                errors++;
                $display("FAIL pause_prelude_pop%0d: got pop=%b, expected %b", i, pop, 4'(1 << ((3 + i) % 4)));
            end
        end
        pause = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (pop !== 4'b0 || push_out !== (i <= 2)) begin
                errors++;
                $display("FAIL pause_cycle%0d: got pop=%b push=%b, expected pop=0000 push=%b", i, pop, push_out, i <= 2);
            end
        end
        pause = 1'b0;
        @(negedge clk);
        checks++;
        if (pop !== 4'b1000) begin
            errors++;
            $display("FAIL pause_resume: got pop=%b, expected 1000", pop);
        end
        wait_drain("pause");
    endtask

    task automatic test_spurious_valid();
        @(negedge clk);
        inj = 4'b0010;
        @(negedge clk);
        inj = 4'b0000;
        checks++;
        if (arb_error !== 1'b1) begin
            errors++;
            $display("FAIL spurious_error: got arb_error=%b, expected 1", arb_error);
        end
        load_word(0, 8'hA8);
        load_word(0, 8'hA9);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (pop !== 4'b0 || push_out !== 1'b0 || arb_error !== 1'b1) begin
                errors++;
                $display("FAIL error_sticky: got pop=%b push=%b err=%b, expected 0000 0 1", pop, push_out, arb_error);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (arb_error !== 1'b0 || pop !== 4'b0) begin
            errors++;
            $display("FAIL error_reset: got err=%b pop=%b, expected 0 and 0000", arb_error, pop);
        end
`ifdef FIFO_POP_ARB_CNT_EN
        checks++;
        if (cnt_word !== 32'h0) begin
            errors++;
            $display("FAIL cnt_word_reset: got %h, expected 0", cnt_word);
        end
`endif
        exp_q.push_back({2'd0, 8'hA8});
        exp_q.push_back({2'd0, 8'hA9});
        reset = 1'b0;
        wait_drain("after_error");
    endtask

    task automatic test_missing_valid();
        @(negedge clk);
        drop = 1'b1;
        load_word(1, 8'hB9);
        repeat (3) @(negedge clk);
        checks++;
        if (arb_error !== 1'b1 || push_out !== 1'b0) begin
            errors++;
            $display("FAIL missing_valid: got err=%b push=%b, expected 1 and 0", arb_error, push_out);
        end
        reset = 1'b1;
        drop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (arb_error !== 1'b0 || pop !== 4'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_valid_recover: got err=%b pop=%b pending=%0d, expected 0 0000 0",
                     arb_error, pop, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_queue();
        test_pause();
        test_spurious_valid();
        test_missing_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
